cas_upload: RTL and testbench

CAS_UPLOAD -- requirements
Module: cas_upload

---
 rtl/cas_upload.sv | 159 +++++++++++++++
 tb/tb_cas_upload.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_upload.sv
// Cassette pulse decoder: turns clock/data pulse pairs from the CPU cassette
// port into bytes captured in a dual-port buffer that the HPS reads back.
module cas_upload #(
  parameter int CLK_HZ  = 42000000,
  parameter int BUF_AW  = 14,
  parameter int HALF_US = 1500,
  parameter int IDLE_US = 5000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cas_pulse,
  input  logic              cas_clear,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [BUF_AW-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [BUF_AW:0]   byte_count,
  output logic              overflow,
  output logic              active
);

  localparam int DIV    = (CLK_HZ / 1000000 > 1) ? CLK_HZ / 1000000 : 1;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMR_W  = $clog2(IDLE_US + 1);
  localparam int BUF_SZ = 1 << BUF_AW;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [TMR_W-1:0] HALF_T   = TMR_W'(HALF_US);
  localparam logic [TMR_W-1:0] IDLE_T   = TMR_W'(IDLE_US);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLK  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [TMR_W-1:0] us_cnt;
  logic             cas_prev;
  logic             pulse;
  logic             timeout;
  logic             bit_in;
  logic             emit;
  logic             wr_en;
  logic [1:0]       state;
  logic [7:0]       shift_p0;
  logic [7:0]       shifted_p0;
  logic [2:0]       bit_cnt_p0;
  logic [7:0]       byte_p1;
  logic             vld_p1;
  logic [7:0]       mem [0:BUF_SZ-1];

  // Microsecond timer holds at IDLE_US so a long silence cannot wrap it.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v >= IDLE_T) ? v : v + TMR_W'(1);
  endfunction

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)      us_cnt <= '0;
    else if (pulse) us_cnt <= '0;
    else if (tick)  us_cnt <= sat_inc(us_cnt);
  end

  // Stage p0: edge detect, bit decode and shift
  assign pulse      = cas_pulse & ~cas_prev;
  assign timeout    = (us_cnt == IDLE_T);
  assign bit_in     = pulse & (us_cnt < HALF_T);
  assign shifted_p0 = {shift_p0[6:0], bit_in};
  assign emit       = ~cas_clear & (state == S_CLK) & (pulse | timeout) &
                      (bit_cnt_p0 == 3'd7);
  assign active     = (state != S_IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cas_prev   <= 1'b0;
      state      <= S_IDLE;
      shift_p0   <= '0;
      bit_cnt_p0 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      cas_prev <= cas_pulse;
      vld_p1   <= emit;
      if (cas_clear) begin
        state      <= S_IDLE;
        shift_p0   <= '0;
        bit_cnt_p0 <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pulse) begin
              state      <= S_CLK;
              shift_p0   <= '0;
              bit_cnt_p0 <= '0;
            end
          end
          S_CLK: begin
            if (pulse) begin
              shift_p0   <= shifted_p0;
              bit_cnt_p0 <= bit_cnt_p0 + 3'd1;
              state      <= bit_in ? S_DATA : S_CLK;
            end else if (timeout) begin
              // The trailing 0 can only matter if it completes the byte (emit).
              state      <= S_IDLE;
              shift_p0   <= '0;
              bit_cnt_p0 <= '0;
            end
          end
          S_DATA: begin
            if (pulse) begin
              state <= S_CLK;
            end else if (timeout) begin
              state      <= S_IDLE;
              shift_p0   <= '0;
              bit_cnt_p0 <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (emit) byte_p1 <= shifted_p0;
  end

  // Stage p1: commit completed byte to the buffer
  assign wr_en = vld_p1 & ~cas_clear & ~byte_count[BUF_AW] & ~ioctl_upload;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (cas_clear) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (vld_p1) begin
      if (byte_count[BUF_AW] || ioctl_upload) overflow   <= 1'b1;
      else                                    byte_count <= byte_count + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[byte_count[BUF_AW-1:0]] <= byte_p1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                          ioctl_din <= 8'h00;
    else if (ioctl_rd && ioctl_upload)  ioctl_din <= mem[ioctl_addr];
  end

endmodule

// File: tb/tb_cas_upload.sv
// Bench for cas_upload: randomized pulse timing scaled 1/100 from the nominal
// thresholds, checked against a byte-level capture model.
module tb_cas_upload;

  localparam int CLK_HZ  = 2000000;
  localparam int CPU     = 2;
  localparam int HALF_US = 15;
  localparam int IDLE_US = 50;
  localparam int AW      = 4;
  localparam int AW_S    = 2;
  localparam int CAP     = 16;
  localparam int CAP_S   = 4;

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic            cas_pulse = 1'b0;
  logic            cas_clear = 1'b0;
  logic            ioctl_upload = 1'b0;
  logic            ioctl_rd = 1'b0;
  logic [AW-1:0]   ioctl_addr = '0;
  logic [AW_S-1:0] ioctl_addr_s = '0;
  logic [7:0]      ioctl_din, ioctl_din_s;
  logic [AW:0]     byte_count;
  logic [AW_S:0]   byte_count_s;
  logic            overflow, overflow_s, active, active_s;

  cas_upload #(.CLK_HZ(CLK_HZ), .BUF_AW(AW), .HALF_US(HALF_US), .IDLE_US(IDLE_US)) dut (
    .clk_sys(clk_sys), .reset(reset), .cas_pulse(cas_pulse), .cas_clear(cas_clear),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .byte_count(byte_count), .overflow(overflow), .active(active));

  cas_upload #(.CLK_HZ(CLK_HZ), .BUF_AW(AW_S), .HALF_US(HALF_US), .IDLE_US(IDLE_US)) dut_s (
    .clk_sys(clk_sys), .reset(reset), .cas_pulse(cas_pulse), .cas_clear(cas_clear),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr_s),
    .ioctl_din(ioctl_din_s), .byte_count(byte_count_s), .overflow(overflow_s), .active(active_s));

  always #5 clk_sys = ~clk_sys;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_mem [CAP];
  logic [7:0] exp_mem_s [CAP_S];
  int         exp_cnt = 0;
  int         exp_cnt_s = 0;
  logic       exp_ovf = 1'b0;
  logic       exp_ovf_s = 1'b0;
  bit         in_stream = 1'b0;
  bit         last_one = 1'b0;

  // Capture model: a whole byte lands at the next free slot unless full or uploading.
  function automatic void model_push(input logic [7:0] b);
    if (ioctl_upload || exp_cnt == CAP) exp_ovf = 1'b1;
    else begin exp_mem[exp_cnt] = b; exp_cnt++; end
    if (ioctl_upload || exp_cnt_s == CAP_S) exp_ovf_s = 1'b1;
    else begin exp_mem_s[exp_cnt_s] = b; exp_cnt_s++; end
  endfunction

  function automatic void model_clear();
    exp_cnt = 0; exp_cnt_s = 0; exp_ovf = 1'b0; exp_ovf_s = 1'b0;
  endfunction

  task automatic pulse_after(input int us);
    repeat (us * CPU - 2) @(negedge clk_sys);
    cas_pulse = 1'b1;
    repeat (2) @(negedge clk_sys);
    cas_pulse = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    int gap;
    for (int i = 7; i > 7 - n; i--) begin
      if (!in_stream)    gap = 3;
      else if (last_one) gap = int'($urandom_range(20, 4));
      else               gap = int'($urandom_range(25, 17));
      pulse_after(gap);
      in_stream = 1'b1;
      if (v[i]) begin
        pulse_after(int'($urandom_range(12, 3)));
        last_one = 1'b1;
      end else begin
        last_one = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
    model_push(v);
  endtask

  task automatic silence();
    repeat (65 * CPU) @(negedge clk_sys);
    in_stream = 1'b0;
    last_one  = 1'b0;
  endtask

  task automatic do_clear();
    cas_clear = 1'b1;
    @(negedge clk_sys);
    cas_clear = 1'b0;
    model_clear();
    @(negedge clk_sys);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [7:0] d, output logic [7:0] ds);
    ioctl_addr   = a;
    ioctl_addr_s = a[AW_S-1:0];
    ioctl_rd     = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    d  = ioctl_din;
    ds = ioctl_din_s;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++; if (ioctl_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h want=00", ioctl_din); end
    checks++; if (byte_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", byte_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_single_byte();
    logic [7:0] d, ds;
    send_byte(8'hA5);
    silence();
    checks++; if (byte_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL a5_count got=%0d want=%0d", byte_count, exp_cnt); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL a5_active got=%b want=0", active); end
    ioctl_upload = 1'b1;
    do_read('0, d, ds);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL a5_read got=%h want=a5", d); end
    @(negedge clk_sys);
    checks++; if (ioctl_din !== 8'hA5) begin failures++; $display("FAIL a5_hold got=%h want=a5", ioctl_din); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, ds;
    do_clear();
    send_byte(8'h00);
    send_byte(8'hFF);
    silence();
    checks++; if (byte_count !== 5'd2) begin failures++; $display("FAIL b2b_count got=%0d want=2", byte_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b want=0", overflow); end
    ioctl_upload = 1'b1;
    do_read(4'd0, d, ds);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL b2b_addr0 got=%h want=00", d); end
    do_read(4'd1, d, ds);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL b2b_addr1 got=%h want=ff", d); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_partial();
    logic [7:0] d, ds;
    do_clear();
    send_bits(8'($urandom), 5);
    repeat (44 * CPU) @(negedge clk_sys);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL partial_active_early got=%b want=1", active); end
    repeat (12 * CPU) @(negedge clk_sys);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL partial_active_late got=%b want=0", active); end
    checks++; if (byte_count !== 5'd0) begin failures++; $display("FAIL partial_count got=%0d want=0", byte_count); end
    silence();
    send_byte(8'h3C);
    silence();
    checks++; if (byte_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL p3c_count got=%0d want=%0d", byte_count, exp_cnt); end
    ioctl_upload = 1'b1;
    do_read(4'd0, d, ds);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL p3c_read got=%h want=3c", d); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_random_overflow();
    logic [7:0] d, ds;
    do_clear();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    silence();
    checks++; if (byte_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", byte_count, exp_cnt); end
    checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rnd_ovf got=%b want=%b", overflow, exp_ovf); end
    checks++; if (byte_count_s !== (AW_S+1)'(exp_cnt_s)) begin failures++; $display("FAIL small_count got=%0d want=%0d", byte_count_s, exp_cnt_s); end
    checks++; if (overflow_s !== exp_ovf_s) begin failures++; $display("FAIL small_ovf got=%b want=%b", overflow_s, exp_ovf_s); end
    ioctl_upload = 1'b1;
    for (int a = 0; a < 6; a++) begin
      do_read(AW'(a), d, ds);
      checks++; if (d !== exp_mem[a]) begin failures++; $display("FAIL rnd_read%0d got=%h want=%h", a, d, exp_mem[a]); end
      if (a < CAP_S) begin
        checks++; if (ds !== exp_mem_s[a]) begin failures++; $display("FAIL small_read%0d got=%h want=%h", a, ds, exp_mem_s[a]); end
      end
    end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_clear();
    logic [7:0] d, ds;
    do_clear();
    checks++; if (byte_count !== 5'd0) begin failures++; $display("FAIL clr_count got=%0d want=0", byte_count); end
    checks++; if (byte_count_s !== 3'd0) begin failures++; $display("FAIL clr_small_count got=%0d want=0", byte_count_s); end
    checks++; if (overflow_s !== 1'b0) begin failures++; $display("FAIL clr_small_ovf got=%b want=0", overflow_s); end
    ioctl_upload = 1'b1;
    do_read(4'd0, d, ds);
    checks++; if (d !== exp_mem[0]) begin failures++; $display("FAIL clr_stale got=%h want=%h", d, exp_mem[0]); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_upload_block();
    logic [7:0] d, ds;
    do_clear();
    send_byte(8'h5A);
    send_byte(8'hC3);
    silence();
    ioctl_upload = 1'b1;
    send_byte(8'($urandom));
    silence();
    checks++; if (byte_count !== 5'd2) begin failures++; $display("FAIL upl_count got=%0d want=2", byte_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL upl_ovf got=%b want=1", overflow); end
    do_read(4'd0, d, ds);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL upl_read got=%h want=5a", d); end
    ioctl_upload = 1'b0;
    do_read(4'd1, d, ds);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL upl_rd_noupload got=%h want=5a", d); end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] d, ds;
    send_bits(8'($urandom), 4);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL mid_active got=%b want=1", active); end
    #2 reset = 1'b1;
    #1;
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL mid_reset_active got=%b want=0", active); end
    checks++; if (ioctl_din !== 8'h00) begin failures++; $display("FAIL mid_reset_din got=%h want=00", ioctl_din); end
    checks++; if (byte_count !== 5'd0) begin failures++; $display("FAIL mid_reset_count got=%0d want=0", byte_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_ovf got=%b want=0", overflow); end
    model_clear();
    in_stream = 1'b0;
    last_one  = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    send_byte(8'h81);
    silence();
    checks++; if (byte_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL r81_count got=%0d want=%0d", byte_count, exp_cnt); end
    ioctl_upload = 1'b1;
    do_read(4'd0, d, ds);
    checks++; if (d !== 8'h81) begin failures++; $display("FAIL r81_read got=%h want=81", d); end
    ioctl_upload = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_partial();
    test_random_overflow();
    test_clear();
    test_upload_block();
    test_reset_midbyte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
